// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback front end.
// Data width and register address width live here.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// In-order writeback buffer: two pushes (a older than b), one pop per cycle.
// Entries are exported so the top can build the scoreboard and bypass.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_a,
    input  wb_entry_t                  entry_a,
    input  logic                       push_b,
    input  wb_entry_t                  entry_b,
    output wb_entry_t                  entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] tail;
    logic [PW-1:0] slot_b;
    logic          pop;
    logic [1:0]    n_push;

    assign pop    = (count != '0);
    assign n_push = {1'b0, push_a} + {1'b0, push_b};
    assign slot_b = push_a ? tail + 1'b1 : tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            // Pushes never land on head while it pops: ready rules forbid a full push.
            if (push_a) begin
                entries[tail] <= entry_a;
            end
            if (push_b) begin
                entries[slot_b] <= entry_b;
            end
            tail  <= tail + PW'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port front end: ALU/load handshake, x0 filter, scoreboard.
// Define WB_BYPASS_EN to add the byp_addr/byp_hit/byp_data forwarding port.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_ADDR_W-1:0]  alu_rd_addr,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [REG_ADDR_W-1:0]  mem_rd_addr,
    input  logic [XLEN-1:0]        mem_data,
    output logic                   rf_write,
    output logic [REG_ADDR_W-1:0]  rf_rd_addr,
    output logic [XLEN-1:0]        rf_rd,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] count
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0]  byp_addr,
    output logic                   byp_hit,
    output logic [XLEN-1:0]        byp_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     entries [DEPTH];
    wb_entry_t     entry_a;
    wb_entry_t     entry_b;
    wb_entry_t     head_e;
    logic [PW-1:0] head;
    logic          push_a;
    logic          push_b;

    // Readiness looks only at registered occupancy; ALU keeps a slot for a load.
    assign mem_ready = (count < CW'(DEPTH));
    assign alu_ready = (count <= CW'(DEPTH - 2));

    assign push_a = mem_valid & mem_ready & (mem_rd_addr != '0);
    assign push_b = alu_valid & alu_ready & (alu_rd_addr != '0);

    assign entry_a = '{valid: 1'b1, addr: mem_rd_addr, data: mem_data};
    assign entry_b = '{valid: 1'b1, addr: alu_rd_addr, data: alu_data};

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_a),
        .entry_a (entry_a),
        .push_b  (push_b),
        .entry_b (entry_b),
        .entries (entries),
        .head    (head),
        .count   (count)
    );

    assign head_e     = entries[head];
    assign rf_write   = (count != '0);
    assign rf_rd_addr = rf_write ? head_e.addr : '0;
    assign rf_rd      = rf_write ? head_e.data : '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                pending[entries[i].addr] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match is the newest value.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        if (byp_addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (entries[idx].valid && entries[idx].addr == byp_addr) begin
                    byp_hit  = 1'b1;
                    byp_data = entries[idx].data;
                end
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH)
    );
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table plus multi-cycle sequences.
// Define WB_BYPASS_EN to also exercise the forwarding port.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd_addr, mem_rd_addr;
    logic [31:0] alu_data, mem_data;
    logic        rf_write;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd;
    logic [31:0] pending;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_writeback #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd_addr (alu_rd_addr),
        .alu_data    (alu_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd_addr (mem_rd_addr),
        .mem_data    (mem_data),
        .rf_write    (rf_write),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd       (rf_rd),
        .pending     (pending),
        .count       (count)
`ifdef WB_BYPASS_EN
        ,
        .byp_addr    (byp_addr),
        .byp_hit     (byp_hit),
        .byp_data    (byp_data)
`endif
    );

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [2:0]  ecnt;
        logic        ew;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic [31:0] epend;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 8; i++) begin
            if (count == 3'd0) break;
            edge_wait();
        end
        chk("drain_empty", count, 3'd0);
    endtask

    task automatic fill_to_three();
        @(negedge clk);
        mem_valid = 1'b1; mem_rd_addr = 5'd11; mem_data = 32'hA1;
        alu_valid = 1'b1; alu_rd_addr = 5'd10; alu_data = 32'hB1;
        edge_wait();
        mem_data = 32'hA2;
        alu_data = 32'hB2;
        edge_wait();
        idle();
    endtask

    initial begin
        vecs[0] = '{1, 5'd9,  32'h99,       0, 5'd0,  32'h0,
                    3'd1, 1, 5'd9,  32'h99,       32'h0000_0200};
        vecs[1] = '{1, 5'd0,  32'hFFFF_FFFF, 0, 5'd0,  32'h0,
                    3'd0, 0, 5'd0,  32'h0,        32'h0};
        vecs[2] = '{1, 5'd9,  32'h99,       1, 5'd0,  32'h55,
                    3'd1, 1, 5'd9,  32'h99,       32'h0000_0200};
        vecs[3] = '{1, 5'd1,  32'h1,        1, 5'd31, 32'hA5A5,
                    3'd2, 1, 5'd31, 32'hA5A5,     32'h8000_0002};
        vecs[4] = '{0, 5'd2,  32'h2,        1, 5'd12, 32'hC0,
                    3'd1, 1, 5'd12, 32'hC0,       32'h0000_1000};

        rst_n = 1'b0;
        idle();
        alu_rd_addr = '0; alu_data = '0;
        mem_rd_addr = '0; mem_data = '0;
`ifdef WB_BYPASS_EN
        byp_addr = '0;
`endif
        #12;
        chk("rst_count", count, 3'd0);
        chk("rst_write", rf_write, 1'b0);
        chk("rst_addr", rf_rd_addr, 5'd0);
        chk("rst_data", rf_rd, 32'd0);
        chk("rst_pending", pending, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            alu_valid = vecs[v].av; alu_rd_addr = vecs[v].aa; alu_data = vecs[v].ad;
            mem_valid = vecs[v].mv; mem_rd_addr = vecs[v].ma; mem_data = vecs[v].md;
            chk("vec_alu_ready", alu_ready, 1'b1);
            chk("vec_mem_ready", mem_ready, 1'b1);
            edge_wait();
            idle();
            chk("vec_count", count, vecs[v].ecnt);
            chk("vec_write", rf_write, vecs[v].ew);
            chk("vec_addr", rf_rd_addr, vecs[v].eaddr);
            chk("vec_data", rf_rd, vecs[v].edata);
            chk("vec_pending", pending, vecs[v].epend);
            drain();
        end

        // Single ALU write: visible for exactly one cycle.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        edge_wait();
        idle();
        chk("x5_write", rf_write, 1'b1);
        chk("x5_addr", rf_rd_addr, 5'd5);
        chk("x5_data", rf_rd, 32'hDEAD_BEEF);
        chk("x5_pend", pending[5], 1'b1);
        edge_wait();
        chk("x5_count_after", count, 3'd0);
        chk("x5_pend_after", pending[5], 1'b0);
        chk("x5_write_after", rf_write, 1'b0);

        // Same-cycle load and ALU to x3: load commits first.
        @(negedge clk);
        mem_valid = 1'b1; mem_rd_addr = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd_addr = 5'd3; alu_data = 32'h22;
        edge_wait();
        idle();
        chk("x3_first", rf_rd, 32'h11);
        chk("x3_pend1", pending, 32'h8);
        edge_wait();
        chk("x3_second", rf_rd, 32'h22);
        chk("x3_addr2", rf_rd_addr, 5'd3);
        chk("x3_pend2", pending, 32'h8);
        edge_wait();
        chk("x3_pend_clr", pending, 32'h0);
        drain();

        // Continuous loads drain one per cycle without stalling.
        @(negedge clk);
        mem_valid = 1'b1; mem_rd_addr = 5'd4; mem_data = 32'h100;
        for (int k = 0; k < 6; k++) begin
            edge_wait();
            chk("hold_count", count, 3'd1);
            chk("hold_ready", mem_ready, 1'b1);
            chk("hold_data", rf_rd, 32'h100 + 32'(k));
            mem_data = 32'h100 + 32'(k + 1);
        end
        idle();
        edge_wait();
        chk("hold_empty", count, 3'd0);

        // Two dual pushes reach DEPTH-1: ALU blocked, load still accepted.
        fill_to_three();
        chk("fill_count", count, 3'd3);
        chk("fill_alu_ready", alu_ready, 1'b0);
        chk("fill_mem_ready", mem_ready, 1'b1);
        chk("fill_head", rf_rd, 32'hB1);
        edge_wait();
        chk("fill_order2", rf_rd, 32'hA2);
        edge_wait();
        chk("fill_order3", rf_rd, 32'hB2);
        chk("fill_addr3", rf_rd_addr, 5'd10);
        drain();

        // Async reset with entries queued discards everything.
        fill_to_three();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 3'd0);
        chk("arst_write", rf_write, 1'b0);
        chk("arst_pending", pending, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            edge_wait();
            chk("post_rst_write", rf_write, 1'b0);
        end

`ifdef WB_BYPASS_EN
        @(negedge clk);
        mem_valid = 1'b1; mem_rd_addr = 5'd7; mem_data = 32'h1;
        alu_valid = 1'b1; alu_rd_addr = 5'd7; alu_data = 32'h2;
        byp_addr = 5'd7;
        edge_wait();
        idle();
        chk("byp_hit", byp_hit, 1'b1);
        chk("byp_young", byp_data, 32'h2);
        byp_addr = 5'd0;
        #1;
        chk("byp_x0", byp_hit, 1'b0);
        byp_addr = 5'd7;
        edge_wait();
        chk("byp_hit2", byp_hit, 1'b1);
        chk("byp_data2", byp_data, 32'h2);
        edge_wait();
        chk("byp_miss", byp_hit, 1'b0);
        chk("byp_miss_data", byp_data, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
